// File: rtl/isr_iter_if.sv
// rtl/isr_iter_if.sv - start/busy/done handshake and operand/result bundle for isr_iter
interface isr_iter_if #(
  parameter int WIDTH = 64
);
  logic               start;
  logic [WIDTH-1:0]   value;
  logic               round_mode;
  logic               busy;
  logic               done;
  logic [WIDTH/2-1:0] result;
  logic [WIDTH/2:0]   remainder;
  logic               sat;

  modport master (
    output start, value, round_mode,
    input  busy, done, result, remainder, sat
  );

  modport slave (
    input  start, value, round_mode,
    output busy, done, result, remainder, sat
  );
endinterface

// File: rtl/isr_iter.sv
// rtl/isr_iter.sv - iterative restoring integer square root, STEPS root bits per clock,
// floor or round-to-nearest result with floor remainder and saturation flag.
module isr_iter #(
  parameter int WIDTH = 64,
  parameter int STEPS = 1
) (
  input  logic      clock,
  input  logic      reset,
  isr_iter_if.slave bus
);
  localparam int HW = WIDTH / 2;
  localparam int RW = HW + 2;
  localparam int N  = WIDTH / (2 * STEPS);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] rad_q, rad_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [HW-1:0]   root_q, root_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic [HW-1:0]   result_q, result_d;
  logic [HW:0]     remainder_q, remainder_d;
  logic            sat_q, sat_d;

  logic [WIDTH-1:0] it_rad;
  logic [RW-1:0]    it_rem;
  logic [RW-1:0]    it_trial;
  logic [HW-1:0]    it_root;
  logic             root_max;
  logic             round_up;

  // Radicand is consumed from the MSB end two bits per iteration.
  always_comb begin
    it_rad   = rad_q;
    it_rem   = rem_q;
    it_root  = root_q;
    it_trial = '0;
    for (int i = 0; i < STEPS; i++) begin
      it_rem   = {it_rem[RW-3:0], it_rad[WIDTH-1 -: 2]};
      it_trial = {it_root, 2'b01};
      it_rad   = {it_rad[WIDTH-3:0], 2'b00};
      if (it_rem >= it_trial) begin
        it_rem  = it_rem - it_trial;
        it_root = {it_root[HW-2:0], 1'b1};
      end else begin
        it_root = {it_root[HW-2:0], 1'b0};
      end
    end
  end

  // value - root^2 > root means the true root lies above root + 0.5.
  assign root_max = &root_q;
  assign round_up = mode_q && (rem_q > {2'b00, root_q});

  always_comb begin
    state_d     = state_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    sat_d       = sat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          rad_d   = bus.value;
          mode_d  = bus.round_mode;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CW'(N - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        rad_d  = it_rad;
        rem_d  = it_rem;
        root_d = it_root;
        if (cnt_q == '0) begin
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ROUND: begin
        remainder_d = rem_q[HW:0];
        sat_d       = round_up && root_max;
        result_d    = (round_up && !root_max) ? root_q + 1'b1 : root_q;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.remainder = remainder_q;
  assign bus.sat       = sat_q;
endmodule
